id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline stage: registers the decoded control bundle, register-file operands,
//  sign-extended immediate and resolved destination register for the EX stage.
//  Detects load-use hazards against the instruction currently in EX and inserts one bubble
//  while stalling PC and IF/ID. Also handles branch flush, downstream hold, and a saturating stall counter.
// PARAMETERS
//  DATA_W   32  operand / immediate width
//  REG_W    5   register address width
//  CNT_W    16  stall counter width
// PORTS
//  clk           in   1       rising-edge clock
//  rst           in   1       synchronous, active-high reset
//  id_wen        in   1       register-file write enable
//  id_alusrc     in   1       1 = immediate as ALU operand B
//  id_aluop      in   3       ALU operation code
//  id_regdst     in   1       1 = destination is rd; 0 = destination is rt
//  id_branch     in   1       branch instruction
//  id_memwrite   in   1       store
//  id_memread    in   1       load
//  id_memtoreg   in   1       0 = write back memory data; 1 = write back ALU result
//  id_rs, id_rt, id_rd  in REG_W  register fields of the instruction in ID
//  id_rdata1, id_rdata2 in DATA_W register-file read data
//  id_imm        in   DATA_W  sign-extended immediate
//  flush_i       in   1       branch taken in EX/MEM; kill the instruction entering EX
//  hold_i        in   1       downstream busy; freeze this stage
//  ex_valid      out  1       EX holds a real instruction
//  ex_wen, ex_alusrc, ex_aluop[2:0], ex_branch, ex_memwrite, ex_memread, ex_memtoreg  out  registered controls
//  ex_rdata1, ex_rdata2, ex_imm  out DATA_W  registered operands
//  ex_rs, ex_rt  out  REG_W   registered source fields, used for forwarding
//  ex_dst        out  REG_W   registered destination = id_regdst ? id_rd : id_rt
//  stall_o       out  1       combinational; freeze PC and IF/ID this cycle
//  stall_cnt     out  CNT_W   number of cycles in which load_use was 1, saturating
// BEHAVIOUR
//  Reset: all ex_* outputs are 0, ex_valid is 0, and stall_cnt is 0. A reset mid-operation discards the in-flight instruction.
//  uses_rt: ~id_alusrc | id_memwrite | id_branch.
//  load_use: ex_valid & ex_memread & ex_wen & (ex_dst != 0) &
//            ((ex_dst == id_rs) | (uses_rt & ex_dst == id_rt)).
//  stall_o: load_use | hold_i. stall_o is 0 while rst is 1.
//  Per-edge update, first matching condition wins:
//    1. rst: reset values.
//    2. flush_i: bubble. All controls, data and ex_valid become 0.
//    3. hold_i: every register holds its value. Flush has priority over hold.
//    4. load_use: bubble. The instruction in ID is re-presented next cycle, so exactly one bubble is inserted per load-use.
//    5. otherwise: capture all id_* fields and set ex_valid to 1.
//  A bubble always has ex_wen, ex_memwrite, ex_memread and ex_branch = 0, so it has no architectural side effects.
//  Latency: 1 cycle, ID to EX.
//  stall_cnt: increments on each edge where load_use is 1 and rst is 0, including edges where hold_i or flush_i is also 1.
//    It saturates at all-ones and never wraps.
//  Destination register 0 never causes a hazard.
// TESTING
//  1. rst for 2 cycles, then release -> all outputs are 0, ex_valid = 0, stall_o = 0.
//  2. LW r3 followed by ADD r4 = r3 + r5 -> stall_o = 1 for exactly 1 cycle; one bubble (ex_valid = 0);
//     next edge captures the ADD; stall_cnt = 1.
//  3. LW r3 followed by ADDI with rt = 3 (alusrc = 1, rt is not a source) -> no stall.
//     Same test with LW r0 -> no stall.
//  4. flush_i and hold_i asserted together while EX holds a valid SW -> next cycle ex_valid = 0 and ex_memwrite = 0.
//  5. hold_i held for 3 cycles with ADD in EX -> outputs unchanged for 3 cycles and stall_o = 1 throughout.
//  6. Preload stall_cnt to 0xFFFE (force), then 3 load-use cycles -> stall_cnt saturates at 0xFFFF.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush,
// downstream hold and a saturating stall-cycle counter.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_wen,
    input  logic              id_alusrc,
    input  logic [2:0]        id_aluop,
    input  logic              id_regdst,
    input  logic              id_branch,
    input  logic              id_memwrite,
    input  logic              id_memread,
    input  logic              id_memtoreg,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              flush_i,
    input  logic              hold_i,
    output logic              ex_valid,
    output logic              ex_wen,
    output logic              ex_alusrc,
    output logic [2:0]        ex_aluop,
    output logic              ex_branch,
    output logic              ex_memwrite,
    output logic              ex_memread,
    output logic              ex_memtoreg,
    output logic [DATA_W-1:0] ex_rdata1,
    output logic [DATA_W-1:0] ex_rdata2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_dst,
    output logic              stall_o,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Everything the EX stage sees, kept as one register so a bubble is a single '0.
    typedef struct packed {
        logic              valid;
        logic              wen;
        logic              alusrc;
        logic [2:0]        aluop;
        logic              branch;
        logic              memwrite;
        logic              memread;
        logic              memtoreg;
        logic [DATA_W-1:0] rdata1;
        logic [DATA_W-1:0] rdata2;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  dst;
    } ex_bundle_t;

    ex_bundle_t        r_ex;
    ex_bundle_t        w_capture;
    ex_bundle_t        w_next;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              w_uses_rt;
    logic              w_load_use;

    // rt only counts as a source when it feeds the ALU, a store or a branch compare.
    assign w_uses_rt = ~id_alusrc | id_memwrite | id_branch;

    // A load in EX whose result is needed by ID cannot be forwarded in time;
    // a load into r0 is harmless because r0 is never written.
    assign w_load_use = r_ex.valid & r_ex.memread & r_ex.wen &
                        (r_ex.dst != {REG_W{1'b0}}) &
                        ((r_ex.dst == id_rs) | (w_uses_rt & (r_ex.dst == id_rt)));

    // Freeze PC and IF/ID; suppressed while reset is active.
    assign stall_o = ~rst & (w_load_use | hold_i);

    // Assemble the bundle for the instruction currently in ID.
    always_comb begin
        w_capture          = '0;
        w_capture.valid    = 1'b1;
        w_capture.wen      = id_wen;
        w_capture.alusrc   = id_alusrc;
        w_capture.aluop    = id_aluop;
        w_capture.branch   = id_branch;
        w_capture.memwrite = id_memwrite;
        w_capture.memread  = id_memread;
        w_capture.memtoreg = id_memtoreg;
        w_capture.rdata1   = id_rdata1;
        w_capture.rdata2   = id_rdata2;
        w_capture.imm      = id_imm;
        w_capture.rs       = id_rs;
        w_capture.rt       = id_rt;
        w_capture.dst      = id_regdst ? id_rd : id_rt;
    end

    // Next EX contents: flush beats hold, hold beats the load-use bubble.
    always_comb begin
        w_next = r_ex;
        if (flush_i) begin
            w_next = '0;
        end else if (hold_i) begin
            w_next = r_ex;
        end else if (w_load_use) begin
            w_next = '0;
        end else begin
            w_next = w_capture;
        end
    end

    // EX pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex <= '0;
        end else begin
            r_ex <= w_next;
        end
    end

    // Count load-use cycles regardless of flush/hold, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_load_use && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign ex_valid    = r_ex.valid;
    assign ex_wen      = r_ex.wen;
    assign ex_alusrc   = r_ex.alusrc;
    assign ex_aluop    = r_ex.aluop;
    assign ex_branch   = r_ex.branch;
    assign ex_memwrite = r_ex.memwrite;
    assign ex_memread  = r_ex.memread;
    assign ex_memtoreg = r_ex.memtoreg;
    assign ex_rdata1   = r_ex.rdata1;
    assign ex_rdata2   = r_ex.rdata2;
    assign ex_imm      = r_ex.imm;
    assign ex_rs       = r_ex.rs;
    assign ex_rt       = r_ex.rt;
    assign ex_dst      = r_ex.dst;
    assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference model predicts EX contents,
// stall_o and stall_cnt each cycle; a second instance with a 4-bit counter
// exercises saturation in a short run.
module tb_id_ex_stage;

    localparam int DW  = 32;
    localparam int RW  = 5;
    localparam int CW  = 16;
    localparam int CWS = 4;

    // {wen, alusrc, aluop[2:0], regdst, branch, memwrite, memread, memtoreg}
    localparam logic [9:0] C_LW   = 10'b1_1_000_0_0_0_1_0;
    localparam logic [9:0] C_ADD  = 10'b1_0_010_1_0_0_0_1;
    localparam logic [9:0] C_ADDI = 10'b1_1_000_0_0_0_0_1;
    localparam logic [9:0] C_SW   = 10'b0_1_000_0_0_1_0_0;
    localparam logic [9:0] C_BEQ  = 10'b0_0_001_0_1_0_0_0;
    localparam logic [9:0] C_NOP  = 10'b0_0_000_0_0_0_0_0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, flush_i, hold_i;
    logic          id_wen, id_alusrc, id_regdst, id_branch, id_memwrite, id_memread, id_memtoreg;
    logic [2:0]    id_aluop;
    logic [RW-1:0] id_rs, id_rt, id_rd;
    logic [DW-1:0] id_rdata1, id_rdata2, id_imm;

    logic          ex_valid, ex_wen, ex_alusrc, ex_branch, ex_memwrite, ex_memread, ex_memtoreg;
    logic [2:0]    ex_aluop;
    logic [DW-1:0] ex_rdata1, ex_rdata2, ex_imm;
    logic [RW-1:0] ex_rs, ex_rt, ex_dst;
    logic          stall_o;
    logic [CW-1:0] stall_cnt;

    logic          s_valid, s_wen, s_alusrc, s_branch, s_memwrite, s_memread, s_memtoreg;
    logic [2:0]    s_aluop;
    logic [DW-1:0] s_rdata1, s_rdata2, s_imm;
    logic [RW-1:0] s_rs, s_rt, s_dst;
    logic          s_stall;
    logic [CWS-1:0] s_cnt;

    id_ex_stage #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_wen(id_wen), .id_alusrc(id_alusrc), .id_aluop(id_aluop), .id_regdst(id_regdst),
        .id_branch(id_branch), .id_memwrite(id_memwrite), .id_memread(id_memread),
        .id_memtoreg(id_memtoreg), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .flush_i(flush_i), .hold_i(hold_i),
        .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
        .ex_branch(ex_branch), .ex_memwrite(ex_memwrite), .ex_memread(ex_memread),
        .ex_memtoreg(ex_memtoreg), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2),
        .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
        .stall_o(stall_o), .stall_cnt(stall_cnt)
    );

    id_ex_stage #(.DATA_W(DW), .REG_W(RW), .CNT_W(CWS)) dut_small (
        .clk(clk), .rst(rst),
        .id_wen(id_wen), .id_alusrc(id_alusrc), .id_aluop(id_aluop), .id_regdst(id_regdst),
        .id_branch(id_branch), .id_memwrite(id_memwrite), .id_memread(id_memread),
        .id_memtoreg(id_memtoreg), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .flush_i(flush_i), .hold_i(hold_i),
        .ex_valid(s_valid), .ex_wen(s_wen), .ex_alusrc(s_alusrc), .ex_aluop(s_aluop),
        .ex_branch(s_branch), .ex_memwrite(s_memwrite), .ex_memread(s_memread),
        .ex_memtoreg(s_memtoreg), .ex_rdata1(s_rdata1), .ex_rdata2(s_rdata2),
        .ex_imm(s_imm), .ex_rs(s_rs), .ex_rt(s_rt), .ex_dst(s_dst),
        .stall_o(s_stall), .stall_cnt(s_cnt)
    );

    typedef struct packed {
        logic          valid;
        logic          wen;
        logic          alusrc;
        logic [2:0]    aluop;
        logic          branch;
        logic          memwrite;
        logic          memread;
        logic          memtoreg;
        logic [DW-1:0] rdata1;
        logic [DW-1:0] rdata2;
        logic [DW-1:0] imm;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] dst;
    } exb_t;

    exb_t           m_ex;
    logic [CW-1:0]  m_cnt;
    logic [CWS-1:0] m_cnt_s;
    exb_t           q_ex[$];
    logic [CW-1:0]  q_cnt[$];
    logic [CWS-1:0] q_cnt_s[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic exb_t main_ex();
        return '{ex_valid, ex_wen, ex_alusrc, ex_aluop, ex_branch, ex_memwrite, ex_memread,
                 ex_memtoreg, ex_rdata1, ex_rdata2, ex_imm, ex_rs, ex_rt, ex_dst};
    endfunction

    function automatic exb_t small_ex();
        return '{s_valid, s_wen, s_alusrc, s_aluop, s_branch, s_memwrite, s_memread,
                 s_memtoreg, s_rdata1, s_rdata2, s_imm, s_rs, s_rt, s_dst};
    endfunction

    task automatic set_id(input logic [9:0] ctl, input logic [RW-1:0] rs, rt, rd);
        {id_wen, id_alusrc, id_aluop, id_regdst, id_branch, id_memwrite, id_memread, id_memtoreg} = ctl;
        id_rs     = rs;
        id_rt     = rt;
        id_rd     = rd;
        id_rdata1 = $urandom;
        id_rdata2 = $urandom;
        id_imm    = $urandom;
    endtask

    task automatic set_ctl(input logic r, input logic f, input logic h);
        rst     = r;
        flush_i = f;
        hold_i  = h;
    endtask

    // One clock: predict, check the combinational stall, clock, compare registered state.
    task automatic step();
        logic           uses_rt, lu, exp_stall;
        exb_t           nxt, got_ex;
        logic [CW-1:0]  e_cnt;
        logic [CWS-1:0] e_cnt_s;
        #1;
        uses_rt = !id_alusrc || id_memwrite || id_branch;
        lu = m_ex.valid && m_ex.memread && m_ex.wen && (m_ex.dst != 5'd0) &&
             ((m_ex.dst == id_rs) || (uses_rt && (m_ex.dst == id_rt)));
        exp_stall = !rst && (lu || hold_i);
        check_val("stall_o", 128'(stall_o), 128'(exp_stall));
        check_val("stall_o_small", 128'(s_stall), 128'(exp_stall));

        if (rst || flush_i) begin
            nxt = '0;
        end else if (hold_i) begin
            nxt = m_ex;
        end else if (lu) begin
            nxt = '0;
        end else begin
            nxt = '{1'b1, id_wen, id_alusrc, id_aluop, id_branch, id_memwrite, id_memread,
                    id_memtoreg, id_rdata1, id_rdata2, id_imm, id_rs, id_rt,
                    (id_regdst ? id_rd : id_rt)};
        end
        if (rst) begin
            m_cnt   = 16'd0;
            m_cnt_s = 4'd0;
        end else if (lu) begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (m_cnt_s != 4'hF) m_cnt_s = m_cnt_s + 4'd1;
        end
        m_ex = nxt;
        q_ex.push_back(nxt);
        q_cnt.push_back(m_cnt);
        q_cnt_s.push_back(m_cnt_s);

        @(posedge clk);
        #1;
        got_ex = main_ex();
        if (q_ex.size() == 0) begin
            check_val("sb_underflow", 128'(0), 128'(1));
        end else begin
            nxt = q_ex.pop_front();
            check_val("ex_bundle", 128'(got_ex), 128'(nxt));
            check_val("ex_bundle_small", 128'(small_ex()), 128'(nxt));
            e_cnt   = q_cnt.pop_front();
            e_cnt_s = q_cnt_s.pop_front();
            check_val("stall_cnt", 128'(stall_cnt), 128'(e_cnt));
            check_val("stall_cnt_small", 128'(s_cnt), 128'(e_cnt_s));
        end
    endtask

    initial begin
        m_ex    = '0;
        m_cnt   = 16'd0;
        m_cnt_s = 4'd0;
        set_ctl(1'b1, 1'b0, 1'b0);
        set_id(C_NOP, 5'd0, 5'd0, 5'd0);

        // 1. Reset for two cycles; hold_i during reset must not raise stall_o.
        step();
        hold_i = 1'b1;
        step();
        set_ctl(1'b0, 1'b0, 1'b0);
        check_val("rst_valid", 128'(ex_valid), 128'(0));
        check_val("rst_bundle", 128'(main_ex()), 128'(0));
        check_val("rst_cnt", 128'(stall_cnt), 128'(0));

        // 2. LW r3 then ADD r4 = r3 + r5: one bubble, ADD re-presented and captured.
        set_id(C_LW, 5'd1, 5'd3, 5'd0);
        step();
        set_id(C_ADD, 5'd3, 5'd5, 5'd4);
        step();
        check_val("lu_bubble_valid", 128'(ex_valid), 128'(0));
        step();
        check_val("lu_add_valid", 128'(ex_valid), 128'(1));
        check_val("lu_add_dst", 128'(ex_dst), 128'(4));
        check_val("lu_cnt_one", 128'(stall_cnt), 128'(1));

        // 3. LW r3 then ADDI with rt=3 (not a source); then LW r0 then ADD using r0.
        set_id(C_LW, 5'd1, 5'd3, 5'd0);
        step();
        set_id(C_ADDI, 5'd2, 5'd3, 5'd0);
        step();
        check_val("addi_no_stall_valid", 128'(ex_valid), 128'(1));
        set_id(C_LW, 5'd1, 5'd0, 5'd0);
        step();
        set_id(C_ADD, 5'd0, 5'd0, 5'd6);
        step();
        check_val("r0_no_stall_valid", 128'(ex_valid), 128'(1));

        // 4. Valid SW in EX, flush and hold together -> bubble.
        set_id(C_SW, 5'd2, 5'd7, 5'd0);
        step();
        check_val("sw_memwrite", 128'(ex_memwrite), 128'(1));
        set_ctl(1'b0, 1'b1, 1'b1);
        set_id(C_ADD, 5'd1, 5'd2, 5'd3);
        step();
        check_val("flush_hold_valid", 128'(ex_valid), 128'(0));
        check_val("flush_hold_memwrite", 128'(ex_memwrite), 128'(0));

        // 5. ADD in EX, hold for three cycles.
        set_ctl(1'b0, 1'b0, 1'b0);
        set_id(C_ADD, 5'd8, 5'd9, 5'd10);
        step();
        hold_i = 1'b1;
        set_id(C_ADD, 5'd11, 5'd12, 5'd13);
        repeat (3) step();
        check_val("hold_dst", 128'(ex_dst), 128'(10));
        hold_i = 1'b0;

        // 6. Load-use held in place by hold_i keeps counting; small counter saturates.
        set_id(C_LW, 5'd1, 5'd3, 5'd0);
        step();
        hold_i = 1'b1;
        set_id(C_ADD, 5'd3, 5'd5, 5'd4);
        repeat (18) step();
        check_val("sat_small", 128'(s_cnt), 128'(4'hF));
        set_ctl(1'b0, 1'b1, 1'b0);
        step();
        set_ctl(1'b0, 1'b0, 1'b0);

        // Random traffic with frequent hazards, flushes, holds and rare resets.
        for (int i = 0; i < 400; i++) begin
            int kind;
            logic [9:0] ctl;
            kind = $urandom_range(0, 6);
            case (kind)
                0: ctl = C_LW;
                1: ctl = C_ADD;
                2: ctl = C_ADDI;
                3: ctl = C_SW;
                4: ctl = C_BEQ;
                5: ctl = C_NOP;
                default: ctl = 10'($urandom);
            endcase
            set_id(ctl, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            set_ctl(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 10),
                    ($urandom_range(0, 99) < 15));
            step();
        end

        check_val("sb_empty", 128'(q_ex.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
